fft_arbiter: RTL

- Time-shares one FFT core between two frame requesters.
  - Requester 0 is the forward path, from input_queue.
  - Requester 1 is the inverse path, from resample.
- Per frame, the block picks a requester and writes the FFT direction on the core's config channel. It then streams exactly FRAME_LEN samples into the core.
- Each core output frame is routed back to the consumer that owns it, using an in-order tag FIFO. Output goes to pitch_detector/resample on the forward side and to audio out on the inverse side.

---
 rtl/fft_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fft_arbiter.sv
// Time-shares one FFT core between a forward and an inverse frame requester and
// routes each core output frame back to its owner through an in-order tag FIFO.
module fft_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] fwd_tdata,
    input  logic                  fwd_tvalid,
    input  logic                  fwd_tlast,
    output logic                  fwd_tready,
    input  logic [DATA_WIDTH-1:0] inv_tdata,
    input  logic                  inv_tvalid,
    input  logic                  inv_tlast,
    output logic                  inv_tready,
    output logic [7:0]            cfg_tdata,
    output logic                  cfg_tvalid,
    input  logic                  cfg_tready,
    output logic [DATA_WIDTH-1:0] core_s_tdata,
    output logic                  core_s_tvalid,
    output logic                  core_s_tlast,
    input  logic                  core_s_tready,
    input  logic [DATA_WIDTH-1:0] core_m_tdata,
    input  logic [USER_WIDTH-1:0] core_m_tuser,
    input  logic                  core_m_tvalid,
    input  logic                  core_m_tlast,
    output logic                  core_m_tready,
    output logic [DATA_WIDTH-1:0] fwd_out_tdata,
    output logic [USER_WIDTH-1:0] fwd_out_tuser,
    output logic                  fwd_out_tvalid,
    output logic                  fwd_out_tlast,
    input  logic                  fwd_out_tready,
    output logic [DATA_WIDTH-1:0] inv_out_tdata,
    output logic [USER_WIDTH-1:0] inv_out_tuser,
    output logic                  inv_out_tvalid,
    output logic                  inv_out_tlast,
    input  logic                  inv_out_tready,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W  = $clog2(TAG_DEPTH + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, CFG, STREAM} state_t;

    state_t              state;
    logic                grant_fwd;
    logic                last_fwd;
    logic [BEAT_W-1:0]   beat;
    logic                tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    tag_count;

    logic                streaming;
    logic                req_tvalid;
    logic                req_tlast;
    logic                in_hs;
    logic                pick_fwd;
    logic                tag_empty;
    logic                head_fwd;
    logic                push;
    logic                pop;

    // Input side: only the granted requester sees the core's ready.
    assign streaming     = (state == STREAM);
    assign req_tvalid    = grant_fwd ? fwd_tvalid : inv_tvalid;
    assign req_tlast     = grant_fwd ? fwd_tlast  : inv_tlast;
    assign core_s_tdata  = grant_fwd ? fwd_tdata  : inv_tdata;
    assign core_s_tvalid = streaming & req_tvalid;
    assign core_s_tlast  = streaming & (beat == LAST_BEAT);
    assign fwd_tready    = streaming &  grant_fwd & core_s_tready;
    assign inv_tready    = streaming & ~grant_fwd & core_s_tready;
    assign in_hs         = core_s_tvalid & core_s_tready;

    // Tie goes to whichever requester was not served last.
    assign pick_fwd      = fwd_tvalid & (~inv_tvalid | ~last_fwd);

    // Output side: the oldest in-flight tag decides where core results go.
    assign tag_empty      = (tag_count == '0);
    assign head_fwd       = tag_mem[rd_ptr];
    assign fwd_out_tdata  = core_m_tdata;
    assign fwd_out_tuser  = core_m_tuser;
    assign fwd_out_tlast  = core_m_tlast;
    assign fwd_out_tvalid = ~tag_empty &  head_fwd & core_m_tvalid;
    assign inv_out_tdata  = core_m_tdata;
    assign inv_out_tuser  = core_m_tuser;
    assign inv_out_tlast  = core_m_tlast;
    assign inv_out_tvalid = ~tag_empty & ~head_fwd & core_m_tvalid;
    assign core_m_tready  = ~tag_empty & (head_fwd ? fwd_out_tready : inv_out_tready);

    assign push = cfg_tvalid & cfg_tready;
    assign pop  = core_m_tvalid & core_m_tready & core_m_tlast;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_fwd  <= 1'b0;
            last_fwd   <= 1'b0;
            beat       <= '0;
            cfg_tvalid <= 1'b0;
            cfg_tdata  <= 8'h00;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= in_hs & (req_tlast != core_s_tlast);
            busy      <= (state != IDLE) | ~tag_empty;
            case (state)
                IDLE: begin
                    if ((tag_count != FULL_CNT) && (fwd_tvalid || inv_tvalid)) begin
                        grant_fwd  <= pick_fwd;
                        last_fwd   <= pick_fwd;
                        cfg_tdata  <= {7'b0, pick_fwd};
                        cfg_tvalid <= 1'b1;
                        state      <= CFG;
                    end
                end
                CFG: begin
                    if (cfg_tready) begin
                        cfg_tvalid <= 1'b0;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (in_hs) begin
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= IDLE;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) tag_mem[wr_ptr] <= grant_fwd;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   tag_count <= tag_count + CNT_W'(1);
                2'b01:   tag_count <= tag_count - CNT_W'(1);
                default: tag_count <= tag_count;
            endcase
        end
    end

endmodule
